// File: rtl/vbsme_pkg.sv
// Shared definitions for the VBSME issue controller: FSM states, decode
// constants and the default watchdog limit.
package vbsme_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        WB    = 2'd3
    } state_e;

    localparam logic [5:0] VBSME_OPCODE   = 6'b011100;
    localparam logic [5:0] VBSME_FUNCT    = 6'b111111;
    localparam int         TIMEOUT_DEF    = 4096;
    localparam int         CNT_W_DEF      = 13;

    // True when the word in ID is a live VBSME instruction.
    function automatic logic is_vbsme(input logic [31:0] instr, input logic valid,
                                      input logic flush);
        return valid & ~flush & (instr[31:26] == VBSME_OPCODE) & (instr[5:0] == VBSME_FUNCT);
    endfunction

endpackage

// File: rtl/vbsme_if.sv
// Pipeline/engine side bundle of the VBSME issue controller. The master is
// the pipeline plus engine environment, the slave is the controller.
interface vbsme_if #(parameter int CNT_W = 13);

    logic [31:0]      Instruction;
    logic             InstrValid;
    logic             Flush;
    logic             EngineDone;
    logic             EngineStart;
    logic             PCStall;
    logic             IFIDStall;
    logic             ResultWrite;
    logic             Busy;
    logic             TimeoutErr;
    logic [CNT_W-1:0] LastLatency;

    modport master (
        output Instruction, InstrValid, Flush, EngineDone,
        input  EngineStart, PCStall, IFIDStall, ResultWrite, Busy, TimeoutErr, LastLatency
    );

    modport slave (
        input  Instruction, InstrValid, Flush, EngineDone,
        output EngineStart, PCStall, IFIDStall, ResultWrite, Busy, TimeoutErr, LastLatency
    );

endinterface

// File: rtl/vbsme_watchdog.sv
// Saturating BUSY-cycle counter with synchronous clear, count enable and a
// terminal-count flag at TIMEOUT_CYCLES-1.
module vbsme_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count while enabled, hold at all-ones instead of wrapping.
    always_ff @(posedge Clk) begin
        if (!Rst)                       cnt_q <= '0;
        else if (clr_i)                 cnt_q <= '0;
        else if (en_i && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == TC_VAL);

endmodule

// File: rtl/vbsme_issue_ctrl.sv
// Issue sequencer for the VBSME instruction: detects it in ID, stalls the
// front end, pulses the engine start, waits for done or timeout and then
// releases the pipeline for exactly one writeback cycle.
module vbsme_issue_ctrl
    import vbsme_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic Clk,
    input  logic Rst,
    vbsme_if.slave bus
);

    localparam logic [CNT_W-1:0] TO_LAT = CNT_W'(TIMEOUT_CYCLES);

    state_e           state_q, state_d;
    logic             done_ok_q, done_ok_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic             match;
    logic             wd_clr, wd_en, wd_tc;
    logic [CNT_W-1:0] wd_cnt;
    logic             start_c, stall_c;

    assign match = is_vbsme(bus.Instruction, bus.InstrValid, bus.Flush);

    vbsme_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_wd (
        .Clk   (Clk),
        .Rst   (Rst),
        .clr_i (wd_clr),
        .en_i  (wd_en),
        .cnt_o (wd_cnt),
        .tc_o  (wd_tc)
    );

    // State, exit-reason, sticky error and latency registers.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q   <= IDLE;
            done_ok_q <= 1'b0;
            err_q     <= 1'b0;
            lat_q     <= '0;
        end else begin
            state_q   <= state_d;
            done_ok_q <= done_ok_d;
            err_q     <= err_d;
            lat_q     <= lat_d;
        end
    end

    // Next state and per-state controls; done has priority over timeout.
    always_comb begin
        state_d   = state_q;
        done_ok_d = done_ok_q;
        err_d     = err_q;
        lat_d     = lat_q;
        wd_clr    = 1'b0;
        wd_en     = 1'b0;
        start_c   = 1'b0;
        stall_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (match) begin
                    stall_c = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                start_c = 1'b1;
                stall_c = 1'b1;
                wd_clr  = 1'b1;
                state_d = BUSY;
            end
            BUSY: begin
                stall_c = 1'b1;
                wd_en   = 1'b1;
                if (bus.EngineDone) begin
                    state_d   = WB;
                    done_ok_d = 1'b1;
                    lat_d     = wd_cnt + 1'b1;
                end else if (wd_tc) begin
                    state_d   = WB;
                    done_ok_d = 1'b0;
                    err_d     = 1'b1;
                    lat_d     = TO_LAT;
                end
            end
            WB: begin
                // Stall released and match ignored: the word advances once.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.EngineStart = start_c;
    assign bus.PCStall     = stall_c;
    assign bus.IFIDStall   = stall_c;
    assign bus.ResultWrite = (state_q == WB) & done_ok_q;
    assign bus.Busy        = (state_q != IDLE);
    assign bus.TimeoutErr  = err_q;
    assign bus.LastLatency = lat_q;

endmodule

// File: tb/tb_vbsme_issue_ctrl.sv
// Bench for vbsme_issue_ctrl: two instances (timeout 16 and 64) share one
// stimulus stream; each is compared every cycle with a cycle-offset model.
module tb_vbsme_issue_ctrl;

    logic        Clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        iv, fl, dn;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 Clk = ~Clk;

    vbsme_if #(.CNT_W(13)) bus_a ();
    vbsme_if #(.CNT_W(13)) bus_b ();

    assign bus_a.Instruction = instr;
    assign bus_a.InstrValid  = iv;
    assign bus_a.Flush       = fl;
    assign bus_a.EngineDone  = dn;
    assign bus_b.Instruction = instr;
    assign bus_b.InstrValid  = iv;
    assign bus_b.Flush       = fl;
    assign bus_b.EngineDone  = dn;

    vbsme_issue_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(13)) dut_a (.Clk(Clk), .Rst(rst_n), .bus(bus_a));
    vbsme_issue_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(13)) dut_b (.Clk(Clk), .Rst(rst_n), .bus(bus_b));

    // Model: per instance, whether an op is live, its cycle offset since the
    // start pulse (0 = start cycle, n = n-th busy cycle) and the WB cycle.
    int T[2] = '{16, 64};
    bit m_known = 1'b0;
    bit m_act[2], m_wb[2], m_wbok[2], m_err[2];
    int m_rel[2], m_lat[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] vb_word();
        return {6'b011100, 20'($urandom), 6'b111111};
    endfunction

    // One clock cycle: drive inputs, check both instances, advance the model.
    task automatic cyc(input bit r, input logic [31:0] ins, input bit v, input bit f, input bit d);
        bit match, idle;
        logic [6:0] got;
        logic [12:0] got_l;
        @(posedge Clk);
        #1;
        rst_n = r; instr = ins; iv = v; fl = f; dn = d;
        match = v && !f && (ins[31:26] == 6'b011100) && (ins[5:0] == 6'b111111);
        @(negedge Clk);
        for (int i = 0; i < 2; i++) begin
            string s;
            s = (i == 0) ? "a" : "b";
            if (i == 0) begin
                got   = {bus_a.EngineStart, bus_a.PCStall, bus_a.IFIDStall, bus_a.ResultWrite,
                         bus_a.Busy, bus_a.TimeoutErr, 1'b0};
                got_l = bus_a.LastLatency;
            end else begin
                got   = {bus_b.EngineStart, bus_b.PCStall, bus_b.IFIDStall, bus_b.ResultWrite,
                         bus_b.Busy, bus_b.TimeoutErr, 1'b0};
                got_l = bus_b.LastLatency;
            end
            idle = !m_act[i] && !m_wb[i];
            if (m_known) begin
                chk({"EngineStart_", s}, 32'(got[6]), 32'(m_act[i] && m_rel[i] == 0));
                chk({"PCStall_", s},     32'(got[5]), 32'(m_act[i] || (idle && match)));
                chk({"IFIDStall_", s},   32'(got[4]), 32'(m_act[i] || (idle && match)));
                chk({"ResultWrite_", s}, 32'(got[3]), 32'(m_wb[i] && m_wbok[i]));
                chk({"Busy_", s},        32'(got[2]), 32'(!idle));
                chk({"TimeoutErr_", s},  32'(got[1]), 32'(m_err[i]));
                chk({"LastLatency_", s}, 32'(got_l),  32'(m_lat[i]));
            end
            if (!r) begin
                m_act[i] = 0; m_wb[i] = 0; m_wbok[i] = 0; m_err[i] = 0;
                m_rel[i] = 0; m_lat[i] = 0;
            end else if (m_wb[i]) begin
                m_wb[i] = 0;
            end else if (!m_act[i]) begin
                if (match) begin m_act[i] = 1; m_rel[i] = 0; end
            end else if (m_rel[i] == 0) begin
                m_rel[i] = 1;
            end else if (d) begin
                m_act[i] = 0; m_wb[i] = 1; m_wbok[i] = 1; m_lat[i] = m_rel[i];
            end else if (m_rel[i] == T[i]) begin
                m_act[i] = 0; m_wb[i] = 1; m_wbok[i] = 0; m_err[i] = 1; m_lat[i] = T[i];
            end else begin
                m_rel[i]++;
            end
        end
        if (!r) m_known = 1'b1;
    endtask

    task automatic nop(input int n);
        for (int k = 0; k < n; k++) cyc(1, 32'h0000_0020, 1, 0, 0);
    endtask

    task automatic rst_seq();
        cyc(0, 32'h0, 0, 0, 0);
        cyc(0, 32'h0, 0, 0, 0);
    endtask

    // Word held in ID from match through WB; done pulsed on busy cycle L.
    task automatic op(input logic [31:0] w, input int L);
        for (int k = 0; k <= L + 2; k++) cyc(1, w, 1, 0, (k == L + 1));
    endtask

    initial begin
        rst_n = 0; instr = '0; iv = 0; fl = 0; dn = 0;
        // basic op, done 20 cycles after start
        rst_seq();
        op(vb_word(), 20);
        nop(4);
        // flushed and bubble VBSME words never start
        rst_seq();
        cyc(1, vb_word(), 1, 1, 0);
        cyc(1, vb_word(), 0, 0, 0);
        nop(2);
        // done on the terminal busy cycle of the 16-cycle instance
        rst_seq();
        op(vb_word(), 16);
        nop(3);
        // timeout with done held low; error must stay set afterwards
        rst_seq();
        for (int k = 0; k < 19; k++) cyc(1, 32'h7000_003f, 1, 0, 0);
        nop(70);
        op(vb_word(), 5);
        nop(3);
        // back-to-back VBSME words
        rst_seq();
        op(vb_word(), 3);
        op(vb_word(), 4);
        nop(3);
        // reset during busy cycle 5, done and stale word ignored afterwards
        rst_seq();
        for (int k = 0; k < 6; k++) cyc(1, 32'h7000_003f, 1, 0, 0);
        cyc(0, 32'h0000_0020, 1, 0, 0);
        cyc(1, 32'h0000_0020, 1, 0, 1);
        nop(4);
        // randomized traffic
        rst_seq();
        for (int k = 0; k < 1500; k++) begin
            logic [31:0] w;
            case ($urandom_range(0, 3))
                0, 1:    w = vb_word();
                2:       w = {6'b011100, 20'($urandom), 6'($urandom_range(0, 62))};
                default: w = $urandom;
            endcase
            cyc($urandom_range(0, 199) != 0, w, $urandom_range(0, 3) != 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vbsme_issue_ctrl.md
Name: vbsme_issue_ctrl

Overview:
Sequences the custom VBSME (SAD search) instruction between the MIPS pipeline and the motion-estimation engine. Decodes the VBSME instruction in ID, freezes PC and IF/ID, sends a one-cycle start to the engine and waits for its done. It then releases the pipeline for exactly one cycle so the instruction can advance with a result-write strobe. Replaces ad-hoc stall logic with a clocked FSM, a timeout watchdog and a latency counter.

Parameters:
VBSME_OPCODE, 6'b011100, opcode field [31:26] identifying the VBSME instruction
VBSME_FUNCT, 6'b111111, funct field [5:0] identifying the VBSME instruction
TIMEOUT_CYCLES, 4096, maximum BUSY cycles before a forced abort
CNT_W, 13, width of the cycle counter; must hold TIMEOUT_CYCLES

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  synchronous reset, active-low
Instruction  input  32  instruction word currently in ID
InstrValid  input  1  Instruction is valid (not a bubble)
Flush  input  1  branch/jump flush of ID this cycle
EngineDone  input  1  engine completion, level or pulse
EngineStart  output  1  one-cycle start pulse to engine
PCStall  output  1  hold PC
IFIDStall  output  1  hold IF/ID register
ResultWrite  output  1  one-cycle strobe: engine result valid for writeback
Busy  output  1  controller not in IDLE
TimeoutErr  output  1  sticky: an operation was aborted by timeout
LastLatency  output  CNT_W  BUSY cycles taken by the most recent operation

Behaviour:
- Reset (Rst=0 at rising Clk): state=IDLE, counter=0, LastLatency=0, TimeoutErr=0. All registered outputs 0. Reset overrides every other event, including mid-operation; no EngineStart is re-issued afterwards. The engine shares Rst.
- match = InstrValid & ~Flush & (Instruction[31:26]==VBSME_OPCODE) & (Instruction[5:0]==VBSME_FUNCT).
- States: IDLE, START, BUSY, WB.
- IDLE:
  - match -> START.
  - PCStall/IFIDStall are combinational: 1 in IDLE when match, so the instruction is held in the detection cycle.
- START:
  - EngineStart=1 for this single cycle; counter cleared to 0.
  - EngineDone ignored.
  - -> BUSY.
- BUSY:
  - Counter increments each cycle, saturating at all-ones.
  - EngineDone=1 -> WB, LastLatency <= counter+1.
  - Else counter==TIMEOUT_CYCLES-1 -> WB, TimeoutErr<=1, LastLatency <= TIMEOUT_CYCLES.
  - Done and timeout in the same cycle: done wins, no error.
- WB:
  - ResultWrite=1 only if exit was via done (0 on timeout).
  - PCStall/IFIDStall=0, so the instruction advances exactly one stage.
  - match is ignored, so the same word cannot retrigger.
  - -> IDLE.
- PCStall=IFIDStall=1 in START and BUSY; 0 in WB and in IDLE without match.
- Busy=1 in START, BUSY and WB.
- Flush is honoured only in IDLE; once START is entered the operation runs to completion (engine has no abort).
- Back-to-back VBSME instructions: the second is detected in the first IDLE cycle after WB. Minimum spacing is therefore START+BUSY(>=1)+WB+IDLE-detect.
- Latency from match to EngineStart: 1 cycle. From EngineDone to ResultWrite: 1 cycle.
- TimeoutErr clears only on reset.

Decomposition:
- Shared package vbsme_pkg:
  - state enum (IDLE, START, BUSY, WB)
  - VBSME_OPCODE / VBSME_FUNCT constants, also used by the main decoder
  - default TIMEOUT_CYCLES
- One natural sub-module: vbsme_watchdog, the saturating CNT_W counter with clear, enable and terminal-count compare. The FSM stays in the top.

Test Plan:
1. Basic op: Rst low 2 cycles, then VBSME word with InstrValid=1. Engine raises EngineDone 20 cycles after EngineStart.
   -> EngineStart pulse 1 cycle after match; stalls high from match until the WB cycle; ResultWrite one cycle after done; LastLatency=20; TimeoutErr=0.
2. Flush: VBSME word with Flush=1 -> no EngineStart, stalls 0, Busy 0.
3. Timeout: TIMEOUT_CYCLES=16, EngineDone held 0.
   -> WB after 16 BUSY cycles; ResultWrite=0; TimeoutErr=1 and sticky; LastLatency=16.
4. Done coincident with terminal count: done asserted on BUSY cycle 16 (TIMEOUT_CYCLES=16) -> ResultWrite=1, TimeoutErr unchanged.
5. Back-to-back: two VBSME words, second present in ID after WB -> two EngineStart pulses. The first word must not retrigger during WB.
6. Reset mid-op: Rst=0 during BUSY cycle 5 -> next cycle state IDLE, all outputs 0, no spurious EngineStart or ResultWrite.
